// File: rtl/req_encoder_32x5_pkg.sv
// Shared widths, state encoding and clear-mask decode for the serial 32->5 request encoder.
package req_encoder_32x5_pkg;

    localparam int unsigned VEC_WIDTH = 32;
    localparam int unsigned IDX_WIDTH = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // 5->32 line decode, used to clear the bit just consumed
    function automatic logic [VEC_WIDTH-1:0] decode_5x32(input logic [IDX_WIDTH-1:0] idx);
        return VEC_WIDTH'(1) << idx;
    endfunction

endpackage

// File: rtl/req_encoder_32x5_prio_enc.sv
// Combinational 32->5 priority encoder, built as a 32->16->8->4->2->1 tree of pairwise selects.
module prio_enc_32x5
    import req_encoder_32x5_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [VEC_WIDTH-1:0] i_vec,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_any
);

    logic [15:0] w_any1;
    logic [0:0]  w_idx1 [16];
    logic [7:0]  w_any2;
    logic [1:0]  w_idx2 [8];
    logic [3:0]  w_any3;
    logic [2:0]  w_idx3 [4];
    logic [1:0]  w_any4;
    logic [3:0]  w_idx4 [2];
    logic        w_any5;
    logic [4:0]  w_idx5;
    logic        w_sel5;

    // Each node picks its low or high half: low wins if LSB_FIRST and it has a request,
    // otherwise high wins whenever it has one.
    for (genvar i = 0; i < 16; i++) begin : g_l1
        assign w_any1[i] = i_vec[2*i] | i_vec[2*i+1];
        assign w_idx1[i] = LSB_FIRST ? ~i_vec[2*i] : i_vec[2*i+1];
    end

    for (genvar i = 0; i < 8; i++) begin : g_l2
        logic w_sel;
        assign w_sel     = LSB_FIRST ? ~w_any1[2*i] : w_any1[2*i+1];
        assign w_any2[i] = w_any1[2*i] | w_any1[2*i+1];
        assign w_idx2[i] = {w_sel, (w_sel ? w_idx1[2*i+1] : w_idx1[2*i])};
    end

    for (genvar i = 0; i < 4; i++) begin : g_l3
        logic w_sel;
        assign w_sel     = LSB_FIRST ? ~w_any2[2*i] : w_any2[2*i+1];
        assign w_any3[i] = w_any2[2*i] | w_any2[2*i+1];
        assign w_idx3[i] = {w_sel, (w_sel ? w_idx2[2*i+1] : w_idx2[2*i])};
    end

    for (genvar i = 0; i < 2; i++) begin : g_l4
        logic w_sel;
        assign w_sel     = LSB_FIRST ? ~w_any3[2*i] : w_any3[2*i+1];
        assign w_any4[i] = w_any3[2*i] | w_any3[2*i+1];
        assign w_idx4[i] = {w_sel, (w_sel ? w_idx3[2*i+1] : w_idx3[2*i])};
    end

    assign w_sel5 = LSB_FIRST ? ~w_any4[0] : w_any4[1];
    assign w_any5 = w_any4[0] | w_any4[1];
    assign w_idx5 = {w_sel5, (w_sel5 ? w_idx4[1] : w_idx4[0])};

    // Empty vector reports index 0 so IDX matches its reset value while idle
    assign o_any = w_any5;
    assign o_idx = w_any5 ? w_idx5 : '0;

endmodule

// File: rtl/req_encoder_32x5.sv
// Serial 32->5 request encoder: loads a multi-hot vector, hands out set-bit indices one per
// handshake in priority order, clears each consumed bit, then pulses done.
module req_encoder_32x5
    import req_encoder_32x5_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load_valid,
    output logic                 o_load_ready,
    input  logic [VEC_WIDTH-1:0] i_load_vec,
    output logic                 o_idx_valid,
    input  logic                 i_idx_ready,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_done,
    output logic [VEC_WIDTH-1:0] o_pending
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [VEC_WIDTH-1:0] r_pending;
    logic [VEC_WIDTH-1:0] w_pending_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic [IDX_WIDTH-1:0] w_idx;
    logic                 w_any;
    logic [VEC_WIDTH-1:0] w_clear_mask;

    prio_enc_32x5 #(
        .LSB_FIRST(LSB_FIRST)
    ) u_prio_enc (
        .i_vec(r_pending),
        .o_idx(w_idx),
        .o_any(w_any)
    );

    assign w_clear_mask = decode_5x32(w_idx);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Load only in IDLE; in BUSY one bit retires per accepted handshake
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load_valid) begin
                    w_pending_nxt = i_load_vec;
                    if (i_load_vec == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (i_idx_ready && w_any) begin
                    w_pending_nxt = r_pending & ~w_clear_mask;
                    if (w_pending_nxt == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_load_ready = (r_state == ST_IDLE);
    assign o_idx_valid  = (r_state == ST_BUSY);
    assign o_idx        = w_idx;
    assign o_done       = r_done;
    assign o_pending    = r_pending;

endmodule

// File: tb/tb_req_encoder_32x5.sv
// Directed bench for req_encoder_32x5: an LSB-first and an MSB-first instance share stimulus.
module tb_req_encoder_32x5;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [31:0] load_vec;
    logic        idx_ready;

    logic        a_load_ready, a_idx_valid, a_done;
    logic [4:0]  a_idx;
    logic [31:0] a_pending;
    logic        b_load_ready, b_idx_valid, b_done;
    logic [4:0]  b_idx;
    logic [31:0] b_pending;

    int unsigned n_checks;
    int unsigned n_fail;

    req_encoder_32x5 #(.LSB_FIRST(1'b1)) u_dut_lsb (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_load_valid(load_valid),
        .o_load_ready(a_load_ready),
        .i_load_vec  (load_vec),
        .o_idx_valid (a_idx_valid),
        .i_idx_ready (idx_ready),
        .o_idx       (a_idx),
        .o_done      (a_done),
        .o_pending   (a_pending)
    );

    req_encoder_32x5 #(.LSB_FIRST(1'b0)) u_dut_msb (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_load_valid(load_valid),
        .o_load_ready(b_load_ready),
        .i_load_vec  (load_vec),
        .o_idx_valid (b_idx_valid),
        .i_idx_ready (idx_ready),
        .o_idx       (b_idx),
        .o_done      (b_done),
        .o_pending   (b_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_vec   = '0;
        idx_ready  = 1'b0;
        #12;
        check("rst_pending", a_pending, 32'h0);
        check("rst_idx", 32'(a_idx), 32'd0);
        check("rst_idx_valid", 32'(a_idx_valid), 32'd0);
        check("rst_load_ready", 32'(a_load_ready), 32'd1);
        check("rst_done", 32'(a_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // priority order, both directions
        load_valid = 1'b1; load_vec = 32'h8000_0011; idx_ready = 1'b1;
        tick();
        load_valid = 1'b0;
        check("lsb_idx0", 32'(a_idx), 32'd0);
        check("lsb_valid0", 32'(a_idx_valid), 32'd1);
        check("lsb_ready0", 32'(a_load_ready), 32'd0);
        check("lsb_pend0", a_pending, 32'h8000_0011);
        check("msb_idx0", 32'(b_idx), 32'd31);
        tick();
        check("lsb_idx1", 32'(a_idx), 32'd4);
        check("lsb_pend1", a_pending, 32'h8000_0010);
        check("msb_idx1", 32'(b_idx), 32'd4);
        check("msb_pend1", b_pending, 32'h0000_0011);
        tick();
        check("lsb_idx2", 32'(a_idx), 32'd31);
        check("lsb_pend2", a_pending, 32'h8000_0000);
        check("lsb_done_early", 32'(a_done), 32'd0);
        check("msb_idx2", 32'(b_idx), 32'd0);
        check("msb_pend2", b_pending, 32'h0000_0001);
        tick();
        check("lsb_done", 32'(a_done), 32'd1);
        check("lsb_valid_end", 32'(a_idx_valid), 32'd0);
        check("lsb_ready_end", 32'(a_load_ready), 32'd1);
        check("msb_done", 32'(b_done), 32'd1);
        check("msb_pend3", b_pending, 32'h0);
        tick();
        check("lsb_done_clr", 32'(a_done), 32'd0);

        // backpressure holds index and pending
        load_valid = 1'b1; load_vec = 32'h0000_0006; idx_ready = 1'b0;
        tick();
        load_valid = 1'b0; load_vec = 32'hxxxx_xxxx;
        for (int i = 0; i < 5; i++) begin
            check("bp_idx", 32'(a_idx), 32'd1);
            check("bp_pend", a_pending, 32'h0000_0006);
            check("bp_valid", 32'(a_idx_valid), 32'd1);
            tick();
        end
        check("bp_msb_idx", 32'(b_idx), 32'd2);
        idx_ready = 1'b1;
        check("bp_idx_rel", 32'(a_idx), 32'd1);
        tick();
        check("bp_idx2", 32'(a_idx), 32'd2);
        check("bp_pend2", a_pending, 32'h0000_0004);
        check("bp_msb_idx2", 32'(b_idx), 32'd1);
        tick();
        check("bp_done", 32'(a_done), 32'd1);
        load_vec = '0;
        tick();

        // zero vector: done without any index
        load_valid = 1'b1; load_vec = 32'h0;
        tick();
        load_valid = 1'b0;
        check("zero_done", 32'(a_done), 32'd1);
        check("zero_valid", 32'(a_idx_valid), 32'd0);
        check("zero_ready", 32'(a_load_ready), 32'd1);
        tick();
        check("zero_done_clr", 32'(a_done), 32'd0);

        // full vector drain, loads during BUSY ignored, reload in the done cycle
        load_valid = 1'b1; load_vec = 32'hFFFF_FFFF;
        tick();
        load_vec = 32'hDEAD_BEEF;
        for (int i = 0; i < 32; i++) begin
            check("full_lsb_idx", 32'(a_idx), 32'(i));
            check("full_msb_idx", 32'(b_idx), 32'(31 - i));
            if (i == 1) check("full_pend1", a_pending, 32'hFFFF_FFFE);
            if (i == 16) check("busy_ready", 32'(a_load_ready), 32'd0);
            tick();
        end
        check("full_done", 32'(a_done), 32'd1);
        check("full_done_ready", 32'(a_load_ready), 32'd1);
        load_vec = 32'h0000_0001;
        tick();
        load_valid = 1'b0;
        check("b2b_valid", 32'(a_idx_valid), 32'd1);
        check("b2b_idx", 32'(a_idx), 32'd0);
        check("b2b_pend", a_pending, 32'h0000_0001);
        check("b2b_done_clr", 32'(a_done), 32'd0);
        tick();
        check("b2b_done", 32'(a_done), 32'd1);
        tick();

        // asynchronous reset while busy
        load_valid = 1'b1; load_vec = 32'h0000_00F0; idx_ready = 1'b0;
        tick();
        load_valid = 1'b0;
        check("arst_pre_pend", a_pending, 32'h0000_00F0);
        check("arst_pre_idx", 32'(a_idx), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pend", a_pending, 32'h0);
        check("arst_valid", 32'(a_idx_valid), 32'd0);
        check("arst_ready", 32'(a_load_ready), 32'd1);
        check("arst_done", 32'(a_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_post_done", 32'(a_done), 32'd0);
        check("arst_post_valid", 32'(a_idx_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
